// File: rtl/jtag_confreg_cdc_ctrl_pkg.sv
// Shared types and limits for the JTAG config-register CDC block.
package jtag_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_ACK      = 2'd1,
    WAIT_ACK_PEND = 2'd2
  } tx_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled back into the legal window.
  function automatic int clamp_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/jtag_confreg_cdc_ctrl_sync.sv
// Multi-flop synchroniser, one chain per bit, async reset to zero.
module jtag_cfg_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/jtag_confreg_cdc_ctrl.sv
// TCK->SoC config transfer via toggle req/ack, plus SoC->TCK status sync.
// Define JTAG_CONFREG_CDC_QUEUE_EN for a one-deep pending update slot.
module jtag_confreg_cdc_ctrl
  import jtag_cfg_pkg::*;
#(
  parameter int               WIDTH       = 9,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             tck_i,
  input  logic             trst_ni,
  input  logic             clk_i,
  input  logic             enable_i,
  input  logic             capture_dr_i,
  input  logic             update_dr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             ovf_o,
  input  logic [WIDTH-1:0] status_i,
  output logic [WIDTH-1:0] status_sync_o,
  output logic [WIDTH-1:0] cfg_o,
  output logic             cfg_valid_o
);

  localparam int SN = clamp_stages(SYNC_STAGES);

  tx_state_e        r_state;
  tx_state_e        w_state_d;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_d;
  logic             r_req_tgl;
  logic             w_req_tgl_d;
  logic             r_ack_seen;
  logic             w_ack_sync;
  logic             w_ack_evt;
  logic             r_ovf;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_upd;
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pend_d;
`endif

  logic             w_req_sync;
  logic             r_req_seen;
  logic             w_req_evt;
  logic             r_ack_tgl;
  logic [WIDTH-1:0] r_cfg;
  logic             r_cfg_valid;

  assign w_upd     = update_dr_i & enable_i;
  assign w_ovf_clr = capture_dr_i & enable_i;
  assign w_ack_evt = w_ack_sync ^ r_ack_seen;

  jtag_cfg_sync #(.STAGES(SN), .WIDTH(1)) u_ack_sync (
    .i_clk   (tck_i),
    .i_rst_n (trst_ni),
    .i_d     (r_ack_tgl),
    .o_q     (w_ack_sync)
  );

  jtag_cfg_sync #(.STAGES(SN), .WIDTH(WIDTH)) u_stat_sync (
    .i_clk   (tck_i),
    .i_rst_n (trst_ni),
    .i_d     (status_i),
    .o_q     (status_sync_o)
  );

  always_comb begin
    w_state_d   = r_state;
    w_hold_d    = r_hold;
    w_req_tgl_d = r_req_tgl;
    w_ovf_set   = 1'b0;
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
    w_pend_d    = r_pend;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_upd) begin
          w_hold_d    = wdata_i;
          w_req_tgl_d = ~r_req_tgl;
          w_state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Ack and new update together: launch straight away.
        if (w_ack_evt && w_upd) begin
          w_hold_d    = wdata_i;
          w_req_tgl_d = ~r_req_tgl;
        end else if (w_ack_evt) begin
          w_state_d   = IDLE;
        end else if (w_upd) begin
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
          w_pend_d    = wdata_i;
          w_state_d   = WAIT_ACK_PEND;
`else
          w_ovf_set   = 1'b1;
`endif
        end
      end
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
      WAIT_ACK_PEND: begin
        if (w_ack_evt) begin
          w_hold_d    = r_pend;
          w_req_tgl_d = ~r_req_tgl;
          w_state_d   = WAIT_ACK;
          if (w_upd) begin
            w_pend_d  = wdata_i;
            w_state_d = WAIT_ACK_PEND;
          end
        end else if (w_upd) begin
          w_pend_d    = wdata_i;
          w_ovf_set   = 1'b1;
        end
      end
`endif
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_req_tgl  <= 1'b0;
      r_ack_seen <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
      r_pend     <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_hold     <= w_hold_d;
      r_req_tgl  <= w_req_tgl_d;
      r_ack_seen <= w_ack_sync;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
`ifdef JTAG_CONFREG_CDC_QUEUE_EN
      r_pend     <= w_pend_d;
`endif
    end
  end

  assign busy_o = (r_state != IDLE);
  assign ovf_o  = r_ovf;

  jtag_cfg_sync #(.STAGES(SN), .WIDTH(1)) u_req_sync (
    .i_clk   (clk_i),
    .i_rst_n (trst_ni),
    .i_d     (r_req_tgl),
    .o_q     (w_req_sync)
  );

  assign w_req_evt = w_req_sync ^ r_req_seen;

  // r_hold is frozen until the ack returns, so it is safe to sample here.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_req_seen  <= 1'b0;
      r_ack_tgl   <= 1'b0;
      r_cfg       <= RESET_VAL;
      r_cfg_valid <= 1'b0;
    end else begin
      r_req_seen  <= w_req_sync;
      r_cfg_valid <= w_req_evt;
      if (w_req_evt) begin
        r_cfg     <= r_hold;
        r_ack_tgl <= ~r_ack_tgl;
      end
    end
  end

  assign cfg_o       = r_cfg;
  assign cfg_valid_o = r_cfg_valid;

endmodule

// File: tb/tb_jtag_confreg_cdc_ctrl.sv
// Directed bench for jtag_confreg_cdc_ctrl (tck 10MHz, clk 50MHz).
module tb_jtag_confreg_cdc_ctrl;

  logic       tck_i = 1'b0;
  logic       clk_i = 1'b0;
  logic       trst_ni;
  logic       enable_i;
  logic       capture_dr_i;
  logic       update_dr_i;
  logic [8:0] wdata_i;
  logic       busy_o;
  logic       ovf_o;
  logic [8:0] status_i;
  logic [8:0] status_sync_o;
  logic [8:0] cfg_o;
  logic       cfg_valid_o;

  int cmp_n = 0;
  int bad_n = 0;
  int pulse_cnt = 0;
  int base;
  int n;
  logic [8:0] vlog [16];

  jtag_confreg_cdc_ctrl dut (
    .tck_i         (tck_i),
    .trst_ni       (trst_ni),
    .clk_i         (clk_i),
    .enable_i      (enable_i),
    .capture_dr_i  (capture_dr_i),
    .update_dr_i   (update_dr_i),
    .wdata_i       (wdata_i),
    .busy_o        (busy_o),
    .ovf_o         (ovf_o),
    .status_i      (status_i),
    .status_sync_o (status_sync_o),
    .cfg_o         (cfg_o),
    .cfg_valid_o   (cfg_valid_o)
  );

  initial forever #50 tck_i = ~tck_i;
  initial begin
    #3;
    forever #10 clk_i = ~clk_i;
  end

  always @(negedge clk_i) begin
    if (cfg_valid_o) begin
      vlog[pulse_cnt % 16] <= cfg_o;
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [8:0] obs,
                     input logic [8:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    trst_ni      = 1'b0;
    enable_i     = 1'b0;
    capture_dr_i = 1'b0;
    update_dr_i  = 1'b0;
    wdata_i      = '0;
    status_i     = '0;
    #230;
    chk("rst_cfg", cfg_o, 9'h000);
    chk("rst_valid", {8'h0, cfg_valid_o}, 9'h0);
    chk("rst_busy", {8'h0, busy_o}, 9'h0);
    chk("rst_ovf", {8'h0, ovf_o}, 9'h0);
    chk("rst_stat", status_sync_o, 9'h000);
    @(negedge tck_i);
    trst_ni = 1'b1;
    repeat (2) @(negedge tck_i);

    // single update, latency and pulse count
    base = pulse_cnt;
    enable_i = 1'b1; update_dr_i = 1'b1; wdata_i = 9'h1A5;
    @(posedge tck_i);
    #1;
    update_dr_i = 1'b0;
    chk("busy_set", {8'h0, busy_o}, 9'h1);
    n = 0;
    while (cfg_o !== 9'h1A5 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("cfg_lat", 9'(n), 9'd3);
    chk("cfg_val", cfg_o, 9'h1A5);
    chk("valid_hi", {8'h0, cfg_valid_o}, 9'h1);
`ifndef JTAG_CONFREG_CDC_QUEUE_EN
    @(negedge tck_i);
    chk("busy_mid", {8'h0, busy_o}, 9'h1);
    update_dr_i = 1'b1; wdata_i = 9'h0FF;
    @(posedge tck_i);
    #1;
    n = 1;
    update_dr_i = 1'b0;
    chk("ovf_set", {8'h0, ovf_o}, 9'h1);
`else
    n = 0;
`endif
    while (busy_o && n < 20) begin
      @(posedge tck_i);
      #1;
      n++;
    end
    chk("busy_lat", 9'(n), 9'd3);
    repeat (10) @(posedge clk_i);
    #1;
    chk("cfg_kept", cfg_o, 9'h1A5);
    chk("one_pulse", 9'(pulse_cnt - base), 9'd1);

    // ovf clear via capture
    @(negedge tck_i);
    capture_dr_i = 1'b1;
    @(posedge tck_i);
    #1;
    capture_dr_i = 1'b0;
    chk("ovf_clr", {8'h0, ovf_o}, 9'h0);

`ifdef JTAG_CONFREG_CDC_QUEUE_EN
    base = pulse_cnt;
    @(negedge tck_i);
    update_dr_i = 1'b1; wdata_i = 9'h001;
    @(negedge tck_i);
    wdata_i = 9'h002;
    @(negedge tck_i);
    wdata_i = 9'h003;
    @(negedge tck_i);
    update_dr_i = 1'b0;
    n = 0;
    while (busy_o && n < 30) begin
      @(posedge tck_i);
      #1;
      n++;
    end
    chk("q_busy", {8'h0, busy_o}, 9'h0);
    repeat (5) @(posedge clk_i);
    #1;
    chk("q_pulses", 9'(pulse_cnt - base), 9'd2);
    chk("q_first", vlog[base % 16], 9'h001);
    chk("q_second", vlog[(base + 1) % 16], 9'h003);
    chk("q_cfg", cfg_o, 9'h003);
    chk("q_ovf", {8'h0, ovf_o}, 9'h1);
`endif
    enable_i = 1'b0;

    // status readback
    @(negedge tck_i);
    status_i = 9'h155;
    @(posedge tck_i);
    #1;
    chk("stat_1", status_sync_o, 9'h000);
    @(posedge tck_i);
    #1;
    chk("stat_2", status_sync_o, 9'h155);

    // update ignored when not selected
    base = pulse_cnt;
    @(negedge tck_i);
    update_dr_i = 1'b1; wdata_i = 9'h1FF;
    @(posedge tck_i);
    #1;
    update_dr_i = 1'b0;
    chk("dis_busy", {8'h0, busy_o}, 9'h0);
    repeat (12) @(posedge clk_i);
    #1;
    chk("dis_busy2", {8'h0, busy_o}, 9'h0);
    chk("dis_cfg", cfg_o, cfg_o === 9'h1A5 ? 9'h1A5 : 9'h003);
    chk("dis_pulse", 9'(pulse_cnt - base), 9'd0);

    // reset in the middle of a transfer
    @(negedge tck_i);
    enable_i = 1'b1; update_dr_i = 1'b1; wdata_i = 9'h0AA;
    @(posedge tck_i);
    #1;
    update_dr_i = 1'b0;
    chk("mid_busy", {8'h0, busy_o}, 9'h1);
    base = pulse_cnt;
    #10;
    trst_ni = 1'b0;
    #1;
    chk("mid_cfg", cfg_o, 9'h000);
    chk("mid_busy0", {8'h0, busy_o}, 9'h0);
    @(negedge tck_i);
    trst_ni = 1'b1;
    repeat (12) @(posedge clk_i);
    #1;
    chk("mid_nopulse", 9'(pulse_cnt - base), 9'd0);
    chk("mid_cfg2", cfg_o, 9'h000);
    chk("mid_busy2", {8'h0, busy_o}, 9'h0);

    // fresh transfer after reset
    base = pulse_cnt;
    @(negedge tck_i);
    update_dr_i = 1'b1; wdata_i = 9'h077;
    @(posedge tck_i);
    #1;
    update_dr_i = 1'b0;
    n = 0;
    while (cfg_o !== 9'h077 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("post_lat", 9'(n), 9'd3);
    n = 0;
    while (busy_o && n < 20) begin
      @(posedge tck_i);
      #1;
      n++;
    end
    chk("post_busy", {8'h0, busy_o}, 9'h0);
    chk("post_cfg", cfg_o, 9'h077);
    chk("post_pulse", 9'(pulse_cnt - base), 9'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
